// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: in-order issue/retire queue between the core and a
// pipelined FPU. Ops are pushed without stalling. They are handed to the FPU
// over valid/ready, and results are collected in acceptance order. Results
// then retire in program order. Per-register busy vectors expose in-flight
// destinations for hazard checks.
module fpu_issue_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int OPE_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // core enqueue side
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [OPE_W-1:0]        in_ope,
  input  logic [DATA_W-1:0]       in_src1,
  input  logic [DATA_W-1:0]       in_src2,
  input  logic [4:0]              in_rd,
  input  logic                    in_rd_is_f,
  // FPU request side
  output logic [OPE_W-1:0]        f_ope_data,
  output logic [DATA_W-1:0]       f_in1_data,
  output logic [DATA_W-1:0]       f_in2_data,
  output logic                    f_in_vld,
  input  logic                    f_in_rdy,
  // FPU result side
  input  logic [DATA_W-1:0]       f_out_data,
  input  logic                    f_out_vld,
  output logic                    f_out_rdy,
  input  logic [2:0]              f_err,
  // writeback side
  output logic                    wb_vld,
  input  logic                    wb_rdy,
  output logic [DATA_W-1:0]       wb_data,
  output logic [4:0]              wb_rd,
  output logic                    wb_rd_is_f,
  // status
  output logic [31:0]             busy_gp,
  output logic [31:0]             busy_fp,
  output logic [$clog2(DEPTH):0]  count,
  output logic [2:0]              err,
  input  logic                    err_clr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // entry storage
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [OPE_W-1:0]  ope_q    [DEPTH];
  logic [DATA_W-1:0] src1_q   [DEPTH];
  logic [DATA_W-1:0] src2_q   [DEPTH];
  logic [4:0]        rd_q     [DEPTH];
  logic              rd_is_f_q[DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic [2:0]        ferr_q   [DEPTH];

  // pointers (MSB is the wrap bit)
  logic [PTR_W-1:0] alloc_q, alloc_d;
  logic [PTR_W-1:0] issue_q, issue_d;
  logic [PTR_W-1:0] cmpl_q,  cmpl_d;
  logic [PTR_W-1:0] head_q,  head_d;

  // FPU request register
  logic              f_vld_q, f_vld_d;
  logic [OPE_W-1:0]  f_ope_q, f_ope_d;
  logic [DATA_W-1:0] f_in1_q, f_in1_d;
  logic [DATA_W-1:0] f_in2_q, f_in2_d;

  logic [2:0] err_q, err_d;

  logic [IDX_W-1:0] alloc_idx, issue_idx, cmpl_idx, head_idx;
  logic             full, enq, issue_slot, pend, cmpl_fire, retire;
  logic [PTR_W-1:0] inflight;

  assign alloc_idx = alloc_q[IDX_W-1:0];
  assign issue_idx = issue_q[IDX_W-1:0];
  assign cmpl_idx  = cmpl_q[IDX_W-1:0];
  assign head_idx  = head_q[IDX_W-1:0];

  assign full       = (alloc_idx == head_idx) && (alloc_q[IDX_W] != head_q[IDX_W]);
  assign in_rdy     = !full && !rst;
  assign enq        = in_vld && in_rdy;
  assign issue_slot = !f_vld_q || f_in_rdy;
  assign pend       = (issue_q != alloc_q);
  // Issued-but-uncompleted ops, minus the one still waiting in the request
  // register, are the ops the FPU actually holds.
  assign inflight   = issue_q - cmpl_q;
  assign f_out_rdy  = !rst && (inflight > PTR_W'(f_vld_q));
  assign cmpl_fire  = f_out_vld && f_out_rdy;

  assign wb_vld     = valid_q[head_idx] && done_q[head_idx];
  assign retire     = wb_vld && wb_rdy;
  // Writeback fields read as zero when the head is not ready, so stale
  // entries left by a flush never leak onto the port.
  assign wb_data    = wb_vld ? result_q[head_idx]  : '0;
  assign wb_rd      = wb_vld ? rd_q[head_idx]      : '0;
  assign wb_rd_is_f = wb_vld ? rd_is_f_q[head_idx] : 1'b0;

  assign f_in_vld   = f_vld_q;
  assign f_ope_data = f_ope_q;
  assign f_in1_data = f_in1_q;
  assign f_in2_data = f_in2_q;
  assign count      = alloc_q - head_q;
  assign err        = err_q;

  // Per-entry one-hot destination decode for the busy vectors.
  logic [31:0] gp_hot [DEPTH];
  logic [31:0] fp_hot [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
    assign gp_hot[gi] = (valid_q[gi] && !rd_is_f_q[gi]) ? (32'd1 << rd_q[gi]) : 32'd0;
    assign fp_hot[gi] = (valid_q[gi] &&  rd_is_f_q[gi]) ? (32'd1 << rd_q[gi]) : 32'd0;
  end

  // OR-reduce the decoded destinations; x0 is never a hazard.
  always_comb begin
    busy_gp = '0;
    busy_fp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_gp = busy_gp | gp_hot[i];
      busy_fp = busy_fp | fp_hot[i];
    end
    busy_gp[0] = 1'b0;
  end

  // Next-state for pointers, the FPU request register and sticky errors.
  always_comb begin
    alloc_d = alloc_q;
    issue_d = issue_q;
    cmpl_d  = cmpl_q;
    head_d  = head_q;
    f_vld_d = f_vld_q;
    f_ope_d = f_ope_q;
    f_in1_d = f_in1_q;
    f_in2_d = f_in2_q;
    err_d   = err_q;
    if (enq) alloc_d = alloc_q + PTR_W'(1);
    if (issue_slot) begin
      f_vld_d = pend || enq;
      if (pend) begin
        f_ope_d = ope_q[issue_idx];
        f_in1_d = src1_q[issue_idx];
        f_in2_d = src2_q[issue_idx];
        issue_d = issue_q + PTR_W'(1);
      end else if (enq) begin
        // Empty pipe: forward the incoming op so it reaches the FPU one
        // cycle after enqueue.
        f_ope_d = in_ope;
        f_in1_d = in_src1;
        f_in2_d = in_src2;
        issue_d = issue_q + PTR_W'(1);
      end
    end
    if (cmpl_fire) cmpl_d = cmpl_q + PTR_W'(1);
    if (retire)    head_d = head_q + PTR_W'(1);
    // A retiring flag set overrides a same-cycle clear.
    if (err_clr) err_d = '0;
    if (retire)  err_d = err_d | ferr_q[head_idx];
  end

  // Pointer, request-register and error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q <= '0;
      issue_q <= '0;
      cmpl_q  <= '0;
      head_q  <= '0;
      f_vld_q <= 1'b0;
      f_ope_q <= '0;
      f_in1_q <= '0;
      f_in2_q <= '0;
      err_q   <= '0;
    end else begin
      alloc_q <= alloc_d;
      issue_q <= issue_d;
      cmpl_q  <= cmpl_d;
      head_q  <= head_d;
      f_vld_q <= f_vld_d;
      f_ope_q <= f_ope_d;
      f_in1_q <= f_in1_d;
      f_in2_q <= f_in2_d;
      err_q   <= err_d;
    end
  end

  // Entry status flags: allocate, complete, retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && alloc_idx == IDX_W'(i)) begin
          valid_q[i] <= 1'b1;
          done_q[i]  <= 1'b0;
        end
        if (cmpl_fire && cmpl_idx == IDX_W'(i)) done_q[i] <= 1'b1;
        if (retire && head_idx == IDX_W'(i))    valid_q[i] <= 1'b0;
      end
    end
  end

  // Entry payload; no reset needed since valid/done gate every use.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && alloc_idx == IDX_W'(i)) begin
        ope_q[i]     <= in_ope;
        src1_q[i]    <= in_src1;
        src2_q[i]    <= in_src2;
        rd_q[i]      <= in_rd;
        rd_is_f_q[i] <= in_rd_is_f;
      end
      if (cmpl_fire && cmpl_idx == IDX_W'(i)) begin
        result_q[i] <= f_out_data;
        ferr_q[i]   <= f_err;
      end
    end
  end

endmodule

// File: doc/fpu_issue_queue.md
# fpu_issue_queue

Parametrised, multi-outstanding FPU issue/retire unit. It sits between the pipelined core and the FPU and replaces the single-op "stall until FPU returns" path. The core pushes FPU operations without stalling, and the unit feeds the FPU over valid/ready. Results retire in order on a writeback port, and per-register busy vectors let the core detect hazards against in-flight destinations.

## Interface
Clock `clk`; reset `rst` is synchronous and active-high.

Parameters:
- DATA_W, 32, operand/result width
- DEPTH, 4, queue entries; power of two, ≥2
- OPE_W, 4, FPU opcode width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_vld  in  1  core offers an op
- in_rdy  out  1  queue can accept (combinational)
- in_ope  in  OPE_W  FPU opcode
- in_src1, in_src2  in  DATA_W  operands (already forwarded by core)
- in_rd  in  5  destination register index
- in_rd_is_f  in  1  destination in FP file (1) or GP file (0)
- f_ope_data  out  OPE_W  FPU opcode (registered)
- f_in1_data, f_in2_data  out  DATA_W  FPU operands (registered)
- f_in_vld  out  1  FPU input valid (registered)
- f_in_rdy  in  1  FPU accepts input
- f_out_data  in  DATA_W  FPU result
- f_out_vld  in  1  FPU result valid
- f_out_rdy  out  1  queue accepts result
- f_err  in  3  FPU error flags, sampled with result
- wb_vld  out  1  head entry complete
- wb_rdy  in  1  core accepts writeback
- wb_data  out  DATA_W  head result
- wb_rd  out  5  head destination
- wb_rd_is_f  out  1  head destination file
- busy_gp  out  32  GP regs with in-flight writes; bit 0 always 0
- busy_fp  out  32  FP regs with in-flight writes
- count  out  log2(DEPTH)+1  occupied entries
- err  out  3  sticky OR of f_err over retired results
- err_clr  in  1  clears err

## Operation
- Entry fields: valid, done, ope, src1, src2, rd, rd_is_f, result, ferr.
- Four pointers, each log2(DEPTH)+1 bits, with the MSB as wrap bit:
  - alloc: tail
  - issue: next to send to FPU
  - cmpl: next to receive a result
  - head: retire
- Empty: alloc==head. Full: same index, different wrap bit.
- Enqueue: in_vld && in_rdy; in_rdy = !full && !rst. Writes the entry at alloc (valid=1, done=0); alloc++.
- Issue: when issue != alloc and (!f_in_vld || f_in_rdy), load f_* from the entry at issue and set f_in_vld=1; issue++.
  - f_in_vld and its data hold stable until f_in_rdy.
  - f_in_vld deasserts after handshake if nothing is pending.
- Completion: f_out_rdy = (cmpl != issue) || (f_in_vld && f_in_rdy is not required); the precise rule is f_out_rdy = at least one op accepted by the FPU and not yet completed.
  - The FPU returns results in acceptance order.
  - On f_out_vld && f_out_rdy: store f_out_data and f_err at cmpl, set done=1; cmpl++.
- Retire: wb_* are combinational from the entry at head; wb_vld = valid && done. On wb_vld && wb_rdy: clear valid; head++; err |= entry ferr.
- err_clr clears err. If err_clr and a retire with nonzero ferr occur in the same cycle, the retiring flags win (err = ferr).
- Busy vectors are combinational ORs over valid entries: busy_gp[rd] for !rd_is_f with rd≠0, busy_fp[rd] for rd_is_f. Duplicate destinations stay busy until the last one retires.
- Full queue: in_rdy=0 even if a retire happens that cycle (no same-cycle bypass).
- Empty queue: wb_vld=0, f_in_vld eventually 0, f_out_rdy=0.
- Reset (including mid-operation) flushes all entries. The FPU shares rst; a dropped in-flight op is discarded without error.

## Timing
- Reset values: f_ope_data=0, f_in1_data=0, f_in2_data=0, f_in_vld=0, f_out_rdy=0, wb_vld=0, wb_data=0, wb_rd=0, wb_rd_is_f=0, busy_gp=0, busy_fp=0, count=0, err=0, in_rdy=0 while rst=1.
- Enqueue edge N → f_in_vld=1 from N+1; busy bit and count visible from N+1.
- FPU result handshake edge M → wb_vld=1 from M+1.
- Retire edge R → busy bit cleared from R+1 (if no other match); slot reusable by an enqueue at R+1.
- Throughput: one enqueue, one issue, one completion and one retire per cycle, all simultaneously.

## Test plan
- Single op: enqueue ope=2, src1=0x3F800000, src2=0x40000000, rd=5 FP. FPU returns 0x40400000 → wb_vld one cycle after result; wb_rd=5, wb_rd_is_f=1; busy_fp[5] is 1 from enqueue+1 until retire+1.
- Fill: DEPTH=4, FPU f_in_rdy=0. Four enqueues → count=4, in_rdy=0; a fifth in_vld is not accepted. Release the FPU → results retire in order 0..3.
- Backpressure: wb_rdy=0 with 4 done entries → f_out_rdy=0 and no loss. Raise wb_rdy → four consecutive retires, one per cycle.
- Duplicate destination: two ops to GP r7 → busy_gp[7] stays 1 until the second retires. An op targeting r0 never sets busy_gp[0].
- Errors: result with f_err=3'b010 → err=010 after retire. err_clr in a later cycle → 000. Simultaneous err_clr and retire with f_err=001 → 001.
- Reset mid-flight: 3 ops queued, 1 issued, rst for one cycle → all outputs at reset values, count=0. A new enqueue after reset completes normally.
